fp_add_align_stage: RTL and testbench

- Pre-alignment pipeline stage of the 32-bit floating-point adder used by the FP add reservation-station functional unit.
- Accepts two IEEE-754 single-precision operands and a result tag, unpacks them, and compares magnitudes to select big/small operands.
- Computes the exponent difference and right-shifts the smaller mantissa with guard/round/sticky retention.
- Feeds the downstream mantissa add/sub and normalise stage through a valid/ready handshake.

---
 rtl/fp_add_align_stage.sv | 219 +++++++++++++++++++++
 tb/tb_fp_add_align_stage.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_align_stage.sv
// Pre-alignment stage of the single-precision FP adder: unpack and magnitude-swap
// the operands, then right-shift the smaller mantissa with guard/round/sticky retention.
module fp_add_align_stage #(
    parameter int TAG_W  = 4,
    parameter int MANT_W = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic [7:0]        out_exp,
    output logic              out_sign,
    output logic              out_eff_sub,
    output logic [MANT_W-1:0] out_mant_big,
    output logic [MANT_W-1:0] out_mant_small,
    output logic              out_is_nan,
    output logic              out_is_inf,
    output logic              out_inf_sign
);

    logic              sign_a, sign_b;
    logic [7:0]        exp_a, exp_b, eff_exp_a, eff_exp_b;
    logic [22:0]       frac_a, frac_b;
    logic [MANT_W-1:0] mant_a, mant_b;
    logic              nan_a, nan_b, inf_a, inf_b;
    logic              a_is_big;
    logic              spec_nan, spec_inf, spec_inf_sign;

    logic              s2_adv, s1_adv;

    logic              s1_valid_q, s1_valid_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    logic [7:0]        s1_exp_q, s1_exp_d;
    logic              s1_sign_q, s1_sign_d;
    logic              s1_eff_sub_q, s1_eff_sub_d;
    logic [MANT_W-1:0] s1_mant_big_q, s1_mant_big_d;
    logic [MANT_W-1:0] s1_mant_small_q, s1_mant_small_d;
    logic [7:0]        s1_shamt_q, s1_shamt_d;
    logic              s1_is_nan_q, s1_is_nan_d;
    logic              s1_is_inf_q, s1_is_inf_d;
    logic              s1_inf_sign_q, s1_inf_sign_d;

    logic              s2_valid_q, s2_valid_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
    logic [7:0]        s2_exp_q, s2_exp_d;
    logic              s2_sign_q, s2_sign_d;
    logic              s2_eff_sub_q, s2_eff_sub_d;
    logic [MANT_W-1:0] s2_mant_big_q, s2_mant_big_d;
    logic [MANT_W-1:0] s2_mant_small_q, s2_mant_small_d;
    logic              s2_is_nan_q, s2_is_nan_d;
    logic              s2_is_inf_q, s2_is_inf_d;
    logic              s2_inf_sign_q, s2_inf_sign_d;

    logic [MANT_W-1:0] shifted, lost_mask, aligned;
    logic              sticky;

    always_comb begin
        sign_a    = in_a[31];
        sign_b    = in_b[31];
        exp_a     = in_a[30:23];
        exp_b     = in_b[30:23];
        frac_a    = in_a[22:0];
        frac_b    = in_b[22:0];
        eff_exp_a = (exp_a == 8'd0) ? 8'd1 : exp_a;
        eff_exp_b = (exp_b == 8'd0) ? 8'd1 : exp_b;
        mant_a    = {(exp_a != 8'd0), frac_a, 3'b000};
        mant_b    = {(exp_b != 8'd0), frac_b, 3'b000};
        nan_a     = (exp_a == 8'hFF) && (frac_a != 23'd0);
        nan_b     = (exp_b == 8'hFF) && (frac_b != 23'd0);
        inf_a     = (exp_a == 8'hFF) && (frac_a == 23'd0);
        inf_b     = (exp_b == 8'hFF) && (frac_b == 23'd0);
        // {exp, frac} orders magnitudes directly; ties keep A as the big operand
        a_is_big  = (in_a[30:0] >= in_b[30:0]);
        spec_nan  = nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b));
        spec_inf  = !spec_nan && (inf_a || inf_b);
        spec_inf_sign = spec_inf && (inf_a ? sign_a : sign_b);
    end

    // Sticky collects every bit pushed past bit 0; shifts of 27+ leave only sticky.
    always_comb begin
        shifted   = '0;
        lost_mask = '0;
        sticky    = 1'b0;
        if (s1_shamt_q >= 8'(MANT_W)) begin
            sticky = |s1_mant_small_q;
        end else begin
            shifted   = s1_mant_small_q >> s1_shamt_q[4:0];
            lost_mask = (MANT_W'(1) << s1_shamt_q[4:0]) - MANT_W'(1);
            sticky    = |(s1_mant_small_q & lost_mask);
        end
        aligned = {shifted[MANT_W-1:1], shifted[0] | sticky};
    end

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_valid_d      = s1_valid_q;
        s1_tag_d        = s1_tag_q;
        s1_exp_d        = s1_exp_q;
        s1_sign_d       = s1_sign_q;
        s1_eff_sub_d    = s1_eff_sub_q;
        s1_mant_big_d   = s1_mant_big_q;
        s1_mant_small_d = s1_mant_small_q;
        s1_shamt_d      = s1_shamt_q;
        s1_is_nan_d     = s1_is_nan_q;
        s1_is_inf_d     = s1_is_inf_q;
        s1_inf_sign_d   = s1_inf_sign_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_tag_d        = in_tag;
                s1_exp_d        = a_is_big ? eff_exp_a : eff_exp_b;
                s1_sign_d       = a_is_big ? sign_a : sign_b;
                s1_eff_sub_d    = sign_a ^ sign_b;
                s1_mant_big_d   = a_is_big ? mant_a : mant_b;
                s1_mant_small_d = a_is_big ? mant_b : mant_a;
                s1_shamt_d      = a_is_big ? (eff_exp_a - eff_exp_b) : (eff_exp_b - eff_exp_a);
                s1_is_nan_d     = spec_nan;
                s1_is_inf_d     = spec_inf;
                s1_inf_sign_d   = spec_inf_sign;
            end
        end
    end

    always_comb begin
        s2_valid_d      = s2_valid_q;
        s2_tag_d        = s2_tag_q;
        s2_exp_d        = s2_exp_q;
        s2_sign_d       = s2_sign_q;
        s2_eff_sub_d    = s2_eff_sub_q;
        s2_mant_big_d   = s2_mant_big_q;
        s2_mant_small_d = s2_mant_small_q;
        s2_is_nan_d     = s2_is_nan_q;
        s2_is_inf_d     = s2_is_inf_q;
        s2_inf_sign_d   = s2_inf_sign_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_tag_d        = s1_tag_q;
                s2_exp_d        = s1_exp_q;
                s2_sign_d       = s1_sign_q;
                s2_eff_sub_d    = s1_eff_sub_q;
                s2_mant_big_d   = s1_mant_big_q;
                s2_mant_small_d = aligned;
                s2_is_nan_d     = s1_is_nan_q;
                s2_is_inf_d     = s1_is_inf_q;
                s2_inf_sign_d   = s1_inf_sign_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q      <= 1'b0;
            s1_tag_q        <= '0;
            s1_exp_q        <= '0;
            s1_sign_q       <= 1'b0;
            s1_eff_sub_q    <= 1'b0;
            s1_mant_big_q   <= '0;
            s1_mant_small_q <= '0;
            s1_shamt_q      <= '0;
            s1_is_nan_q     <= 1'b0;
            s1_is_inf_q     <= 1'b0;
            s1_inf_sign_q   <= 1'b0;
            s2_valid_q      <= 1'b0;
            s2_tag_q        <= '0;
            s2_exp_q        <= '0;
            s2_sign_q       <= 1'b0;
            s2_eff_sub_q    <= 1'b0;
            s2_mant_big_q   <= '0;
            s2_mant_small_q <= '0;
            s2_is_nan_q     <= 1'b0;
            s2_is_inf_q     <= 1'b0;
            s2_inf_sign_q   <= 1'b0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_tag_q        <= s1_tag_d;
            s1_exp_q        <= s1_exp_d;
            s1_sign_q       <= s1_sign_d;
            s1_eff_sub_q    <= s1_eff_sub_d;
            s1_mant_big_q   <= s1_mant_big_d;
            s1_mant_small_q <= s1_mant_small_d;
            s1_shamt_q      <= s1_shamt_d;
            s1_is_nan_q     <= s1_is_nan_d;
            s1_is_inf_q     <= s1_is_inf_d;
            s1_inf_sign_q   <= s1_inf_sign_d;
            s2_valid_q      <= s2_valid_d;
            s2_tag_q        <= s2_tag_d;
            s2_exp_q        <= s2_exp_d;
            s2_sign_q       <= s2_sign_d;
            s2_eff_sub_q    <= s2_eff_sub_d;
            s2_mant_big_q   <= s2_mant_big_d;
            s2_mant_small_q <= s2_mant_small_d;
            s2_is_nan_q     <= s2_is_nan_d;
            s2_is_inf_q     <= s2_is_inf_d;
            s2_inf_sign_q   <= s2_inf_sign_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_tag        = s2_tag_q;
    assign out_exp        = s2_exp_q;
    assign out_sign       = s2_sign_q;
    assign out_eff_sub    = s2_eff_sub_q;
    assign out_mant_big   = s2_mant_big_q;
    assign out_mant_small = s2_mant_small_q;
    assign out_is_nan     = s2_is_nan_q;
    assign out_is_inf     = s2_is_inf_q;
    assign out_inf_sign   = s2_inf_sign_q;

endmodule

// File: tb/tb_fp_add_align_stage.sv
// Bench for fp_add_align_stage: directed vectors plus randomized traffic with
// random backpressure, checked against an arithmetic reference model.
module tb_fp_add_align_stage;

    typedef struct packed {
        logic [3:0]  tag;
        logic [7:0]  exp;
        logic        sign;
        logic        eff_sub;
        logic [26:0] mant_big;
        logic [26:0] mant_small;
        logic        is_nan;
        logic        is_inf;
        logic        inf_sign;
    } pkt_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  e;
        logic        s;
        logic        es;
        logic [26:0] mb;
        logic [26:0] ms;
        logic        nan;
        logic        inf;
        logic        isg;
    } dir_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_tag;
    logic [7:0]  out_exp;
    logic        out_sign;
    logic        out_eff_sub;
    logic [26:0] out_mant_big;
    logic [26:0] out_mant_small;
    logic        out_is_nan;
    logic        out_is_inf;
    logic        out_inf_sign;

    int   vectors = 0;
    int   miscompares = 0;
    pkt_t exp_q[$];

    fp_add_align_stage #(.TAG_W(4), .MANT_W(27)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_exp(out_exp), .out_sign(out_sign),
        .out_eff_sub(out_eff_sub), .out_mant_big(out_mant_big),
        .out_mant_small(out_mant_small), .out_is_nan(out_is_nan),
        .out_is_inf(out_is_inf), .out_inf_sign(out_inf_sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value-level arithmetic on the IEEE fields.
    function automatic pkt_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] tag);
        pkt_t p;
        int unsigned ea, eb, xa, xb, big_e, small_e;
        longint unsigned ma, mb, m_big, m_small, q, r, sh;
        bit na, nb, ia, ib, a_big;
        ea = a[30:23];
        eb = b[30:23];
        xa = (ea == 0) ? 1 : ea;
        xb = (eb == 0) ? 1 : eb;
        ma = (((ea != 0) ? 64'd8388608 : 64'd0) + a[22:0]) * 8;
        mb = (((eb != 0) ? 64'd8388608 : 64'd0) + b[22:0]) * 8;
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        a_big   = (ea > eb) || ((ea == eb) && (a[22:0] >= b[22:0]));
        big_e   = a_big ? xa : xb;
        small_e = a_big ? xb : xa;
        m_big   = a_big ? ma : mb;
        m_small = a_big ? mb : ma;
        sh      = big_e - small_e;
        if (sh >= 27) begin
            q = (m_small != 0) ? 1 : 0;
        end else begin
            q = m_small / (64'd1 << sh);
            r = m_small % (64'd1 << sh);
            if (r != 0) q = q | 1;
        end
        p.tag        = tag;
        p.exp        = 8'(big_e);
        p.sign       = a_big ? a[31] : b[31];
        p.eff_sub    = a[31] ^ b[31];
        p.mant_big   = 27'(m_big);
        p.mant_small = 27'(q);
        p.is_nan     = na || nb || (ia && ib && (a[31] != b[31]));
        p.is_inf     = !p.is_nan && (ia || ib);
        p.inf_sign   = p.is_inf ? (ia ? a[31] : b[31]) : 1'b0;
        return p;
    endfunction

    function automatic pkt_t actual_pkt();
        pkt_t p;
        p = '{out_tag, out_exp, out_sign, out_eff_sub, out_mant_big, out_mant_small,
              out_is_nan, out_is_inf, out_inf_sign};
        return p;
    endfunction

    function automatic logic [31:0] rand_fp(input logic [7:0] near_exp);
        logic [7:0]  e;
        logic [22:0] f;
        int k;
        k = $urandom_range(0, 9);
        f = 23'($urandom);
        if ($urandom_range(0, 4) == 0) f = '0;
        case (k)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2, 3, 4, 5: e = near_exp + 8'($urandom_range(0, 40)) - 8'd20;
            default: e = 8'($urandom);
        endcase
        return {1'($urandom), e, f};
    endfunction

    always @(posedge clk) begin
        if (rst) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(ref_model(in_a, in_b, in_tag));
    end

    task automatic test_reset();
        pkt_t act;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_tag = '0;
        repeat (2) @(negedge clk);
        #1;
        act = actual_pkt();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        vectors++;
        if (act !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0", act);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        dir_t dv[10];
        pkt_t act, e;
        logic [62:0] got, want;
        dv[0] = '{32'h3F800000, 32'h3F000000, 8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h2000000, 1'b0, 1'b0, 1'b0};
        dv[1] = '{32'h3F000000, 32'hBF800000, 8'h7F, 1'b1, 1'b1, 27'h4000000, 27'h2000000, 1'b0, 1'b0, 1'b0};
        dv[2] = '{32'h40400000, 32'h40400000, 8'h80, 1'b0, 1'b0, 27'h6000000, 27'h6000000, 1'b0, 1'b0, 1'b0};
        dv[3] = '{32'h4B800000, 32'h3F800001, 8'h97, 1'b0, 1'b0, 27'h4000000, 27'h0000005, 1'b0, 1'b0, 1'b0};
        dv[4] = '{32'h53800000, 32'h3F800000, 8'hA7, 1'b0, 1'b0, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0};
        dv[5] = '{32'h53800000, 32'h00000000, 8'hA7, 1'b0, 1'b0, 27'h4000000, 27'h0000000, 1'b0, 1'b0, 1'b0};
        dv[6] = '{32'h7F800000, 32'h3F800000, 8'hFF, 1'b0, 1'b0, 27'h4000000, 27'h0000001, 1'b0, 1'b1, 1'b0};
        dv[7] = '{32'h7F800000, 32'hFF800000, 8'hFF, 1'b0, 1'b1, 27'h4000000, 27'h4000000, 1'b1, 1'b0, 1'b0};
        dv[8] = '{32'h7FC00000, 32'h3F800000, 8'hFF, 1'b0, 1'b0, 27'h6000000, 27'h0000001, 1'b1, 1'b0, 1'b0};
        dv[9] = '{32'h00000001, 32'h00800000, 8'h01, 1'b0, 1'b0, 27'h4000000, 27'h0000008, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = dv[i].a; in_b = dv[i].b;
            in_tag = 4'(i + 3); out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL dir%0d_early_valid: got %b expected 0", i, out_valid);
            end
            @(negedge clk);
            #1;
            act = actual_pkt();
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL dir%0d_latency: out_valid got %b expected 1", i, out_valid);
            end
            got  = {act.tag, act.exp, act.sign, act.eff_sub, act.mant_big, act.mant_small,
                    act.is_nan, act.is_inf, act.inf_sign};
            want = {4'(i + 3), dv[i].e, dv[i].s, dv[i].es, dv[i].mb, dv[i].ms,
                    dv[i].nan, dv[i].inf, dv[i].isg};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL dir%0d_fields: got %h expected %h", i, got, want);
            end
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL dir%0d_model: got %h expected <none queued>", i, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL dir%0d_model: got %h expected %h", i, act, e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        pkt_t act, prev_act, e;
        logic [31:0] ops_a[5], ops_b[5];
        int idx = 0, outs = 0;
        bit stalled_prev = 0, saw_stall = 0, exp_rdy;
        prev_act = '0;
        for (int i = 0; i < 5; i++) begin
            ops_a[i] = rand_fp(8'h80);
            ops_b[i] = rand_fp(ops_a[i][30:23]);
        end
        for (int c = 0; c < 40 && (idx < 5 || outs < 5); c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 6);
            in_valid  = (idx < 5);
            in_a      = ops_a[idx % 5];
            in_b      = ops_b[idx % 5];
            in_tag    = 4'(idx);
            #1;
            act = actual_pkt();
            exp_rdy = out_ready || (exp_q.size() < 2);
            if (!in_ready) saw_stall = 1;
            vectors++;
            if (in_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL b2b_in_ready c%0d: got %b expected %b", c, in_ready, exp_rdy);
            end
            if (stalled_prev) begin
                vectors++;
                if ({out_valid, act} !== {1'b1, prev_act}) begin
                    miscompares++;
                    $display("FAIL b2b_stable c%0d: got %b/%h expected 1/%h", c, out_valid, act, prev_act);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_extra_out: got %h expected <none>", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e || act.tag !== 4'(outs)) begin
                        miscompares++;
                        $display("FAIL b2b_data tag%0d: got %h expected %h", outs, act, e);
                    end
                end
                outs++;
            end
            if (in_valid && in_ready) idx++;
            stalled_prev = out_valid && !out_ready;
            prev_act = act;
        end
        in_valid = 1'b0;
        vectors++;
        if (outs != 5 || idx != 5 || !saw_stall) begin
            miscompares++;
            $display("FAIL b2b_totals: got acc=%0d out=%0d stall=%0d expected 5/5/1", idx, outs, saw_stall);
        end
    endtask

    task automatic test_reset_midflight();
        pkt_t act, e;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        in_a = 32'h3F800000; in_b = 32'h3F000000; in_tag = 4'd10;
        @(negedge clk);
        in_a = 32'h40400000; in_b = 32'hC0000000; in_tag = 4'd11;
        @(negedge clk);
        rst = 1'b1; in_a = 32'h41200000; in_b = 32'h3E800000; in_tag = 4'd12;
        @(negedge clk);
        #1;
        act = actual_pkt();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rstmid_valid_ready: got %b%b expected 01", out_valid, in_ready);
        end
        vectors++;
        if (act !== '0) begin
            miscompares++;
            $display("FAIL rstmid_data: got %h expected 0", act);
        end
        rst = 1'b0; out_ready = 1'b1;
        in_a = 32'h42C80000; in_b = 32'hBF400000; in_tag = 4'd13;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_ghost: out_valid got %b expected 0", out_valid);
        end
        @(negedge clk);
        #1;
        act = actual_pkt();
        e = ref_model(32'h42C80000, 32'hBF400000, 4'd13);
        vectors++;
        if (out_valid !== 1'b1 || act !== e || exp_q.size() != 1) begin
            miscompares++;
            $display("FAIL rstmid_resume: got v=%b %h q=%0d expected v=1 %h q=1", out_valid, act, exp_q.size(), e);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic test_random();
        pkt_t act, prev_act, e;
        logic [31:0] ca, cb;
        int idx = 0, outs = 0;
        int n = 300;
        bit stalled_prev = 0, exp_rdy;
        prev_act = '0;
        ca = rand_fp(8'h80);
        cb = rand_fp(ca[30:23]);
        for (int c = 0; c < 4000 && (idx < n || outs < n); c++) begin
            @(negedge clk);
            out_ready = (idx >= n) ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_valid  = (idx < n) && ($urandom_range(0, 3) != 0);
            in_a = ca; in_b = cb; in_tag = 4'(idx);
            #1;
            act = actual_pkt();
            exp_rdy = out_ready || (exp_q.size() < 2);
            vectors++;
            if (in_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL rnd_in_ready c%0d: got %b expected %b", c, in_ready, exp_rdy);
            end
            if (stalled_prev) begin
                vectors++;
                if ({out_valid, act} !== {1'b1, prev_act}) begin
                    miscompares++;
                    $display("FAIL rnd_stable c%0d: got %b/%h expected 1/%h", c, out_valid, act, prev_act);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_extra_out: got %h expected <none>", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        miscompares++;
                        $display("FAIL rnd_data #%0d: got %h expected %h", outs, act, e);
                    end
                end
                outs++;
            end
            if (in_valid && in_ready) begin
                idx++;
                ca = rand_fp(8'h80);
                cb = rand_fp(ca[30:23]);
            end
            stalled_prev = out_valid && !out_ready;
            prev_act = act;
        end
        in_valid = 1'b0;
        vectors++;
        if (outs != n || idx != n) begin
            miscompares++;
            $display("FAIL rnd_totals: got acc=%0d out=%0d expected %0d/%0d", idx, outs, n, n);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
